// File: rtl/ram_arb_pkg.sv
// Shared types for the RAM data-port arbiter: FSM states and master indices.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker; the master not granted last wins a tie.
module rr_pick2
  import ram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = '0;
    if (req[0] && (!req[1] || last == M1)) gnt[0] = 1'b1;
    else if (req[1])                       gnt[1] = 1'b1;
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares the RAM data port between the load/store unit (M0) and the loader/debug
// engine (M1) with round-robin arbitration, lockable ownership and registered reads.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  m0_req,
  input  logic                  m0_lock,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_lock,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  mem_wEn,
  input  logic [DATA_WIDTH-1:0] mem_read_data
);

  arb_state_e state;
  logic       last;
  logic [1:0] pick;
  logic [1:0] gnt;

  rr_pick2 u_pick (
    .req  ({m1_req, m0_req}),
    .last (last),
    .gnt  (pick)
  );

  // An owner is served whenever it requests; the other master is shut out.
  always_comb begin
    gnt = '0;
    case (state)
      IDLE:    gnt = pick;
      OWN0:    gnt[0] = m0_req;
      OWN1:    gnt[1] = m1_req;
      default: gnt = '0;
    endcase
  end

  assign m0_gnt = gnt[0];
  assign m1_gnt = gnt[1];

  assign mem_address    = gnt[1] ? m1_addr  : m0_addr;
  assign mem_write_data = gnt[1] ? m1_wdata : m0_wdata;
  // Gated by reset so an asserted reset kills a write before the edge lands.
  assign mem_wEn        = reset & ((gnt[0] & m0_we) | (gnt[1] & m1_we));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      last      <= M1;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      m0_rvalid <= gnt[0] & ~m0_we;
      m1_rvalid <= gnt[1] & ~m1_we;
      if (gnt[0] && !m0_we) m0_rdata <= mem_read_data;
      if (gnt[1] && !m1_we) m1_rdata <= mem_read_data;

      if (gnt[0])      last <= M0;
      else if (gnt[1]) last <= M1;

      case (state)
        IDLE: begin
          if (gnt[0])      state <= m0_lock ? OWN0 : IDLE;
          else if (gnt[1]) state <= m1_lock ? OWN1 : IDLE;
        end
        OWN0: begin
          if (m0_req)        state <= m0_lock ? OWN0 : IDLE;
          else if (!m0_lock) state <= IDLE;
        end
        OWN1: begin
          if (m1_req)        state <= m1_lock ? OWN1 : IDLE;
          else if (!m1_lock) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomized and directed bench for ram_port_arbiter against an ownership/round-robin
// reference model with its own shadow memory.
module tb_ram_port_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_v [2];
  logic        lock_v [2];
  logic        we_v [2];
  logic [15:0] addr_v [2];
  logic [31:0] wdata_v [2];
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_wEn;
  logic [31:0] m0_rdata, m1_rdata, mem_write_data, mem_read_data;
  logic [15:0] mem_address;

  logic [31:0] ram  [0:63];
  logic [31:0] smem [0:63];

  int          owner;
  int          last_m;
  logic        exp_rv [2];
  logic [31:0] exp_rd [2];
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clock = ~clock;

  assign mem_read_data = ram[mem_address[5:0]];
  always @(posedge clock) if (mem_wEn) ram[mem_address[5:0]] <= mem_write_data;

  ram_port_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) dut (
    .clock(clock), .reset(reset),
    .m0_req(req_v[0]), .m0_lock(lock_v[0]), .m0_we(we_v[0]),
    .m0_addr(addr_v[0]), .m0_wdata(wdata_v[0]),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(req_v[1]), .m1_lock(lock_v[1]), .m1_we(we_v[1]),
    .m1_addr(addr_v[1]), .m1_wdata(wdata_v[1]),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_wEn(mem_wEn), .mem_read_data(mem_read_data)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_grant();
    if (owner >= 0) return req_v[owner] ? owner : -1;
    if (req_v[0] && req_v[1]) return (last_m == 1) ? 0 : 1;
    if (req_v[0]) return 0;
    if (req_v[1]) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    owner = -1;
    last_m = 1;
    for (int m = 0; m < 2; m++) begin
      exp_rv[m] = 1'b0;
      exp_rd[m] = '0;
    end
  endtask

  task automatic idle_inputs();
    for (int m = 0; m < 2; m++) begin
      req_v[m] = 1'b0; lock_v[m] = 1'b0; we_v[m] = 1'b0;
      addr_v[m] = '0; wdata_v[m] = '0;
    end
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic step(output int g);
    #1;
    g = model_grant();
    check("m0_gnt", 64'(m0_gnt), 64'(g == 0));
    check("m1_gnt", 64'(m1_gnt), 64'(g == 1));
    check("mem_wEn", 64'(mem_wEn), 64'(g >= 0 && we_v[g]));
    if (g >= 0) check("mem_address", 64'(mem_address), 64'(addr_v[g]));
    if (g >= 0 && we_v[g]) check("mem_write_data", 64'(mem_write_data), 64'(wdata_v[g]));
    @(posedge clock);
    exp_rv[0] = 1'b0;
    exp_rv[1] = 1'b0;
    if (g >= 0) begin
      if (we_v[g]) smem[addr_v[g][5:0]] = wdata_v[g];
      else begin
        exp_rv[g] = 1'b1;
        exp_rd[g] = smem[addr_v[g][5:0]];
      end
      last_m = g;
      owner = lock_v[g] ? g : -1;
    end else if (owner >= 0 && !lock_v[owner]) begin
      owner = -1;
    end
    #1;
    check("m0_rvalid", 64'(m0_rvalid), 64'(exp_rv[0]));
    check("m1_rvalid", 64'(m1_rvalid), 64'(exp_rv[1]));
    check("m0_rdata", 64'(m0_rdata), 64'(exp_rd[0]));
    check("m1_rdata", 64'(m1_rdata), 64'(exp_rd[1]));
    @(negedge clock);
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    model_reset();
    #1;
    check("rst_m0_rvalid", 64'(m0_rvalid), 64'd0);
    check("rst_m1_rvalid", 64'(m1_rvalid), 64'd0);
    check("rst_m0_rdata", 64'(m0_rdata), 64'd0);
    check("rst_m1_rdata", 64'(m1_rdata), 64'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    int g;
    for (int i = 0; i < 64; i++) begin
      smem[i] = $urandom;
      ram[i]  = smem[i];
    end
    smem[4] = 32'h0000_0013;
    ram[4]  = 32'h0000_0013;
    @(negedge clock);
    do_reset();

    // M0-only read right after reset.
    req_v[0] = 1'b1; addr_v[0] = 16'd4;
    step(g);
    check("t1_rdata", 64'(m0_rdata), 64'h13);
    idle_inputs();
    step(g);

    // Both request every cycle: alternation starting with M0.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_v[0] = 1'b1; addr_v[0] = 16'(i);
      req_v[1] = 1'b1; addr_v[1] = 16'(32 + i);
      step(g);
      check("t2_order", 64'(g), 64'(i % 2));
    end
    idle_inputs();
    step(g);

    // Locked M1 burst writes 8..11 while M0 waits to read 9.
    req_v[1] = 1'b1; lock_v[1] = 1'b1; we_v[1] = 1'b1;
    addr_v[1] = 16'd8; wdata_v[1] = 32'hDEAD_BEEF;
    step(g);
    req_v[0] = 1'b1; addr_v[0] = 16'd9;
    for (int i = 1; i < 4; i++) begin
      addr_v[1] = 16'(8 + i); wdata_v[1] = 32'hDEAD_BEEF + 32'(i);
      lock_v[1] = (i < 3);
      step(g);
    end
    req_v[1] = 1'b0; lock_v[1] = 1'b0; we_v[1] = 1'b0;
    step(g);
    check("t3_rdata", 64'(m0_rdata), 64'hDEAD_BEF0);
    idle_inputs();
    step(g);

    // Owner idles with lock held: M0 starved, no write strobe.
    req_v[1] = 1'b1; lock_v[1] = 1'b1; we_v[1] = 1'b1;
    addr_v[1] = 16'd20; wdata_v[1] = 32'h1234_5678;
    step(g);
    req_v[1] = 1'b0; we_v[1] = 1'b0;
    req_v[0] = 1'b1; addr_v[0] = 16'd21;
    step(g);
    step(g);
    lock_v[1] = 1'b0;
    step(g);
    step(g);
    idle_inputs();
    step(g);

    // Read then write addr 12 back-to-back, then read it again.
    req_v[0] = 1'b1; addr_v[0] = 16'd12;
    step(g);
    we_v[0] = 1'b1; wdata_v[0] = 32'hA5A5_0C0C;
    step(g);
    we_v[0] = 1'b0;
    step(g);
    check("t6_rdata", 64'(m0_rdata), 64'hA5A5_0C0C);
    idle_inputs();
    step(g);

    // Randomized traffic; a request is held unchanged until it is granted.
    g = -1;
    for (int n = 0; n < 400; n++) begin
      for (int m = 0; m < 2; m++) begin
        if (!req_v[m] || g == m) begin
          req_v[m]   = ($urandom_range(0, 2) != 0);
          lock_v[m]  = ($urandom_range(0, 3) == 0);
          we_v[m]    = $urandom_range(0, 1) == 1;
          addr_v[m]  = 16'($urandom_range(0, 63));
          wdata_v[m] = $urandom;
        end
      end
      step(g);
    end
    idle_inputs();
    step(g);

    // Reset asserted mid-cycle during an M0 write.
    req_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 16'd8; wdata_v[0] = 32'hFFFF_FFFF;
    #1;
    reset = 1'b0;
    #1;
    check("t5_wEn", 64'(mem_wEn), 64'd0);
    check("t5_rvalid", 64'(m0_rvalid), 64'd0);
    check("t5_rdata", 64'(m0_rdata), 64'd0);
    @(posedge clock);
    #1;
    check("t5_mem8", 64'(ram[8]), 64'(smem[8]));
    @(negedge clock);
    do_reset();
    step(g);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
